// File: rtl/cpu_wait_sequencer_if.sv
// rtl/cpu_wait_sequencer_if.sv - CPU bus / phi2 handshake bundle for the wait-state sequencer
interface cpu_wait_sequencer_if;
  logic [15:0] adr;
  logic        rw;
  logic [7:0]  dat_in;
  logic        rdy;
  logic        phi2;
  logic        phi2_via;
  logic        cyc_end;
  logic        stretching;
  logic [7:0]  dat_out;
  logic        dat_oe;
  logic        timeout;

  modport master (
    output adr, rw, dat_in, rdy,
    input  phi2, phi2_via, cyc_end, stretching, dat_out, dat_oe, timeout
  );

  modport slave (
    input  adr, rw, dat_in, rdy,
    output phi2, phi2_via, cyc_end, stretching, dat_out, dat_oe, timeout
  );
endinterface

// File: rtl/cpu_wait_sequencer.sv
// rtl/cpu_wait_sequencer.sv - phi2/VIA clock generation with per-region wait states and rdy timeout
module cpu_wait_sequencer #(
  parameter int TMO_MAX = 255,
  parameter int W0_RST  = 6,
  parameter int W1_RST  = 1
) (
  input logic                  clk,
  input logic                  rst,
  cpu_wait_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {LOW, HIGH, WAIT, RDYHOLD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_MAX - 1);

  state_t     state, stateNext;
  logic [3:0] cnt, cntNext;
  logic [7:0] tmo, tmoNext;
  logic       setTimeout;
  logic [3:0] wcfg [4];
  logic [3:0] regionWait;
  logic       regHit;
  logic [7:0] regData;
  logic       leaving;
  logic       readOe;
  logic       regWrite;
  logic       unusedBits;

  assign unusedBits = &{1'b0, bus.dat_in[7:4]};

  // First match wins: the YMF window sits inside the I/O page ahead of the VIAs.
  always_comb begin
    regionWait = 4'd0;
    if (bus.adr >= 16'h9F40 && bus.adr <= 16'h9F41)
      regionWait = wcfg[0];
    else if (bus.adr >= 16'h9F00 && bus.adr <= 16'h9F1F)
      regionWait = wcfg[1];
    else if (bus.adr >= 16'hC000)
      regionWait = wcfg[2];
    else if (bus.adr >= 16'hA000 && bus.adr <= 16'hBFFF)
      regionWait = wcfg[3];
  end

  assign regHit  = (bus.adr >= 16'h9F70) && (bus.adr <= 16'h9F74);
  assign regData = bus.adr[2] ? {7'b0, bus.timeout} : {4'b0, wcfg[bus.adr[1:0]]};

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    tmoNext    = tmo;
    setTimeout = 1'b0;
    case (state)
      LOW: begin
        stateNext = HIGH;
        cntNext   = regionWait;
      end
      HIGH, WAIT: begin
        if (cnt != 4'd0) begin
          stateNext = WAIT;
          cntNext   = cnt - 4'd1;
        end else if (!bus.rdy) begin
          stateNext = RDYHOLD;
          tmoNext   = 8'd0;
        end else begin
          stateNext = LOW;
        end
      end
      RDYHOLD: begin
        // A ready device always beats the guard, even on the expiry cycle.
        if (bus.rdy) begin
          stateNext = LOW;
        end else if (tmo == TMO_LAST) begin
          stateNext  = LOW;
          setTimeout = 1'b1;
        end else begin
          tmoNext = tmo + 8'd1;
        end
      end
      default: stateNext = LOW;
    endcase
  end

  assign leaving  = (state != LOW) && (stateNext == LOW);
  assign readOe   = (stateNext != LOW) && bus.rw && regHit;
  assign regWrite = leaving && !bus.rw && regHit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= LOW;
      cnt            <= 4'd0;
      tmo            <= 8'd0;
      wcfg[0]        <= 4'(W0_RST);
      wcfg[1]        <= 4'(W1_RST);
      wcfg[2]        <= 4'd0;
      wcfg[3]        <= 4'd0;
      bus.phi2       <= 1'b0;
      bus.phi2_via   <= 1'b0;
      bus.cyc_end    <= 1'b0;
      bus.stretching <= 1'b0;
      bus.dat_oe     <= 1'b0;
      bus.dat_out    <= 8'd0;
      bus.timeout    <= 1'b0;
    end else begin
      state          <= stateNext;
      cnt            <= cntNext;
      tmo            <= tmoNext;
      bus.phi2       <= (stateNext != LOW);
      bus.phi2_via   <= ~bus.phi2_via;
      bus.cyc_end    <= leaving;
      bus.stretching <= (stateNext == WAIT) || (stateNext == RDYHOLD);
      bus.dat_oe     <= readOe;
      bus.dat_out    <= readOe ? regData : 8'd0;
      if (regWrite && !bus.adr[2])
        wcfg[bus.adr[1:0]] <= bus.dat_in[3:0];
      // Expiry set outranks a status write landing on the same edge.
      if (setTimeout)
        bus.timeout <= 1'b1;
      else if (regWrite && bus.adr[2])
        bus.timeout <= 1'b0;
    end
  end

endmodule
